// File: rtl/saturn_alu_exec_pkg.sv
// Shared ALU command codes and helpers for the decoder and execution block.
// Register/opcode encodings are the common definitions used across the core.
package saturn_alu_exec_pkg;

    localparam logic [4:0] ALU_REG_A    = 5'd0;
    localparam logic [4:0] ALU_REG_B    = 5'd1;
    localparam logic [4:0] ALU_REG_C    = 5'd2;
    localparam logic [4:0] ALU_REG_D    = 5'd3;
    localparam logic [4:0] ALU_REG_P    = 5'd4;
    localparam logic [4:0] ALU_REG_IMM  = 5'd5;
    localparam logic [4:0] ALU_REG_NONE = 5'd31;

    localparam logic [4:0] ALU_OP_NOP  = 5'd0;
    localparam logic [4:0] ALU_OP_COPY = 5'd1;
    localparam logic [4:0] ALU_OP_EXCH = 5'd2;
    localparam logic [4:0] ALU_OP_ADD  = 5'd3;
    localparam logic [4:0] ALU_OP_SUB  = 5'd4;
    localparam logic [4:0] ALU_OP_AND  = 5'd5;
    localparam logic [4:0] ALU_OP_OR   = 5'd6;

    localparam logic [3:0] INSTR_TYPE_ALU  = 4'd0;
    localparam logic [3:0] INSTR_TYPE_GOTO = 4'd1;
    localparam logic [3:0] INSTR_TYPE_JUMP = 4'd2;
    localparam logic [3:0] INSTR_TYPE_NOP  = 4'd15;

    typedef struct packed {
        logic [4:0] dest;
        logic [4:0] src_1;
        logic [4:0] src_2;
        logic [3:0] imm;
        logic [4:0] op;
    } alu_cmd_t;

    // A..D occupy codes 0..3
    function automatic logic is_gpr(input logic [4:0] sel);
        return sel[4:2] == 3'b000;
    endfunction

    function automatic logic is_binary_op(input logic [4:0] op);
        return (op == ALU_OP_ADD) || (op == ALU_OP_SUB) ||
               (op == ALU_OP_AND) || (op == ALU_OP_OR);
    endfunction

    function automatic logic cmd_legal(input logic [4:0] dest,
                                       input logic [4:0] src_2,
                                       input logic [4:0] op);
        logic ok;
        ok = 1'b1;
        if (op > ALU_OP_OR)
            ok = 1'b0;
        if (!(is_gpr(dest) || (dest == ALU_REG_P)))
            ok = 1'b0;
        if ((dest == ALU_REG_P) && (op != ALU_OP_COPY))
            ok = 1'b0;
        if (is_binary_op(op) && (src_2 == ALU_REG_NONE))
            ok = 1'b0;
        return ok;
    endfunction

    // Immediate and P only contribute to the first processed nibble
    function automatic logic [3:0] pick_src(input logic [4:0]  sel,
                                            input logic [15:0] nibs,
                                            input logic [3:0]  imm,
                                            input logic [3:0]  p,
                                            input logic        first);
        logic [3:0] v;
        v = 4'd0;
        if (is_gpr(sel))
            v = nibs[{sel[1:0], 2'b00} +: 4];
        else if (sel == ALU_REG_IMM)
            v = first ? imm : 4'd0;
        else if (sel == ALU_REG_P)
            v = first ? p : 4'd0;
        return v;
    endfunction

endpackage

// File: rtl/saturn_alu_exec_nibble.sv
// One-nibble combinational ALU slice; the carry chain is threaded by the caller.
module saturn_alu_nibble
    import saturn_alu_exec_pkg::*;
(
    input  logic [4:0] op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] result,
    output logic       cout
);

    logic [4:0] wide;

    always_comb begin
        wide   = 5'd0;
        result = a;
        cout   = cin;
        case (op)
            ALU_OP_ADD: begin
                wide   = {1'b0, a} + {1'b0, b} + {4'd0, cin};
                result = wide[3:0];
                cout   = wide[4];
            end
            ALU_OP_SUB: begin
                // bit 4 of the 5-bit difference is the borrow
                wide   = {1'b0, a} - {1'b0, b} - {4'd0, cin};
                result = wide[3:0];
                cout   = wide[4];
            end
            ALU_OP_AND: result = a & b;
            ALU_OP_OR:  result = a | b;
            default:    result = a;
        endcase
    end

endmodule

// File: rtl/saturn_alu_exec.sv
// Latches one decoded ALU command and executes it nibble-serially on A-D and P,
// one nibble per phase-3 strobe, reporting busy/done to the sequencer.
module saturn_alu_exec
    import saturn_alu_exec_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [3:0]  i_phases,
    input  logic [1:0]  i_phase,
    input  logic [31:0] i_cycle_ctr,
    input  logic        i_debug_cycle,
    input  logic        i_instr_execute,
    input  logic [3:0]  i_instr_type,
    input  logic [4:0]  i_alu_reg_dest,
    input  logic [4:0]  i_alu_reg_src_1,
    input  logic [4:0]  i_alu_reg_src_2,
    input  logic [3:0]  i_alu_imm_value,
    input  logic [4:0]  i_alu_opcode,
    input  logic [3:0]  i_field_start,
    input  logic [3:0]  i_field_last,
    output logic        o_alu_busy,
    output logic        o_alu_done,
    output logic [3:0]  o_reg_p,
    output logic        o_carry,
    input  logic [4:0]  i_dbg_reg_sel,
    input  logic [3:0]  i_dbg_nib_idx,
    output logic [3:0]  o_dbg_nibble
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t     state_reg, state_next;
    alu_cmd_t   cmd_reg, cmd_next;
    logic [3:0] idx_reg, left_reg, p_reg;
    logic       first_reg, carry_reg;

    logic        accept, strobe, legal, p_wr;
    logic [63:0] regs [4];
    logic [15:0] cur_nibs;
    logic [3:0]  dest_wr, src_wr;
    logic [3:0]  dest_nib, src1_nib, src2_nib, nib_result;
    logic        nib_cout;
    logic        unused_inputs;

    assign unused_inputs = ^{i_phase, i_cycle_ctr, i_phases[2:0]};

    assign accept = (state_reg == ST_IDLE) && i_instr_execute &&
                    (i_instr_type == INSTR_TYPE_ALU) && !i_debug_cycle;
    assign strobe = (state_reg == ST_RUN) && i_phases[3] && !i_debug_cycle;

    assign legal = cmd_legal(i_alu_reg_dest, i_alu_reg_src_2, i_alu_opcode);

    always_comb begin
        cmd_next       = '0;
        cmd_next.dest  = i_alu_reg_dest;
        cmd_next.src_1 = i_alu_reg_src_1;
        cmd_next.src_2 = i_alu_reg_src_2;
        cmd_next.imm   = i_alu_imm_value;
        // illegal commands are folded into a single-strobe NOP here
        cmd_next.op    = legal ? i_alu_opcode : ALU_OP_NOP;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        o_alu_busy = 1'b0;
        o_alu_done = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept)
                    state_next = ST_RUN;
            end
            ST_RUN: begin
                o_alu_busy = 1'b1;
                if (strobe && (left_reg == 4'd0))
                    state_next = ST_DONE;
            end
            ST_DONE: begin
                o_alu_busy = 1'b1;
                o_alu_done = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cmd_reg   <= '0;
            idx_reg   <= 4'd0;
            left_reg  <= 4'd0;
            first_reg <= 1'b0;
            carry_reg <= 1'b0;
            p_reg     <= 4'd0;
        end else if (accept) begin
            cmd_reg   <= cmd_next;
            idx_reg   <= i_field_start;
            left_reg  <= (legal && (i_alu_reg_dest != ALU_REG_P)) ?
                         (i_field_last - i_field_start) : 4'd0;
            first_reg <= 1'b1;
            carry_reg <= 1'b0;
        end else if (strobe) begin
            idx_reg   <= idx_reg + 4'd1;
            left_reg  <= left_reg - 4'd1;
            first_reg <= 1'b0;
            carry_reg <= nib_cout;
            if (p_wr)
                p_reg <= src1_nib;
        end
    end

    assign p_wr = strobe && (cmd_reg.dest == ALU_REG_P) && (cmd_reg.op == ALU_OP_COPY);

    assign dest_nib = is_gpr(cmd_reg.dest) ? cur_nibs[{cmd_reg.dest[1:0], 2'b00} +: 4] : 4'd0;
    assign src1_nib = pick_src(cmd_reg.src_1, cur_nibs, cmd_reg.imm, p_reg, first_reg);
    assign src2_nib = pick_src(cmd_reg.src_2, cur_nibs, cmd_reg.imm, p_reg, first_reg);

    saturn_alu_nibble u_nibble (
        .op     (cmd_reg.op),
        .a      (src1_nib),
        .b      (src2_nib),
        .cin    (carry_reg),
        .result (nib_result),
        .cout   (nib_cout)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_reg
            logic [63:0] val_reg;

            assign dest_wr[gi] = strobe && is_gpr(cmd_reg.dest) &&
                                 (cmd_reg.dest[1:0] == 2'(gi)) && (cmd_reg.op != ALU_OP_NOP);
            assign src_wr[gi]  = strobe && (cmd_reg.op == ALU_OP_EXCH) && is_gpr(cmd_reg.src_1) &&
                                 (cmd_reg.src_1[1:0] == 2'(gi));

            // when EXCH names the same register twice both writes carry the same nibble
            always_ff @(posedge i_clk) begin
                if (i_reset)
                    val_reg <= 64'd0;
                else if (dest_wr[gi])
                    val_reg[{idx_reg, 2'b00} +: 4] <= nib_result;
                else if (src_wr[gi])
                    val_reg[{idx_reg, 2'b00} +: 4] <= dest_nib;
            end

            assign regs[gi]              = val_reg;
            assign cur_nibs[gi*4 +: 4]   = val_reg[{idx_reg, 2'b00} +: 4];
        end
    endgenerate

    assign o_reg_p      = p_reg;
    assign o_carry      = carry_reg;
    assign o_dbg_nibble = is_gpr(i_dbg_reg_sel) ?
                          regs[i_dbg_reg_sel[1:0]][{i_dbg_nib_idx, 2'b00} +: 4] : 4'd0;

endmodule

// File: doc/saturn_alu_exec.md
# saturn_alu_exec

Execution-side consumer of the instruction decoder's ALU command bus. It latches one decoded ALU command (dest, sources, immediate, opcode, field), then executes it nibble-serially on the working registers A–D and the pointer P, one nibble per phase-3 strobe. It reports busy and done back to the sequencer and exposes P and carry to the rest of the core.

## Interface
- No parameters; register and opcode codes come from the shared ALU definitions.
- `i_clk` in 1: clock.
- `i_reset` in 1: reset, synchronous, active-high.
- `i_phases` in 4: one-hot phase strobes.
- `i_phase` in 2: phase index, debug print only.
- `i_cycle_ctr` in 32: debug print only.
- `i_debug_cycle` in 1: freeze all progress while high.
- `i_instr_execute` in 1: decoder command-valid.
- `i_instr_type` in 4: command accepted only if `INSTR_TYPE_ALU`.
- `i_alu_reg_dest`, `i_alu_reg_src_1`, `i_alu_reg_src_2` in 5: `ALU_REG_*` codes.
- `i_alu_imm_value` in 4: immediate nibble.
- `i_alu_opcode` in 5: `ALU_OP_*`.
- `i_field_start`, `i_field_last` in 4: first and last nibble index.
- `o_alu_busy` out 1: command in progress.
- `o_alu_done` out 1: one-clock completion pulse.
- `o_reg_p` out 4: P register.
- `o_carry` out 1: carry/borrow of last ADD/SUB.
- `i_dbg_reg_sel` in 5: debug read register select.
- `i_dbg_nib_idx` in 4: debug read nibble index.
- `o_dbg_nibble` out 4: combinational debug read; 0 for non-A–D selects.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE:** on a clock with `i_instr_execute` high, `i_instr_type == INSTR_TYPE_ALU`, and `!i_debug_cycle`:
  - latch all command inputs;
  - set nibble index to `i_field_start`;
  - clear `o_carry`;
  - go to RUN.
  - Other instruction types are ignored.
- **RUN:** on each clock with `i_phases[3]` and `!i_debug_cycle`, process one nibble at index k:
  - **COPY:** `dest[k] <= src1[k]`.
  - **EXCH:** swap `dest[k]` and `src1[k]`.
  - **ADD / SUB:** `dest[k] <= src1[k] ± src2[k] ± carry`, binary (hex) arithmetic; the carry chain is internal, and the final carry/borrow goes to `o_carry`.
  - **AND / OR:** bitwise.
  - **NOP:** no write.
- **IMM source:** yields `i_alu_imm_value` on the first processed nibble and 0 on every later nibble.
- **Dest P:** legal only with COPY; P is always a single-nibble op (`P <= src1` first nibble) regardless of field.
- **Illegal commands:** dest NONE or IMM, dest P with a non-COPY op, or a binary op with src2 NONE. These execute as NOP: one strobe, no writes.
- **Nibble count:** N = ((last − start) mod 16) + 1. The index wraps 15→0, so start=14, last=1 processes 14, 15, 0, 1.
- **Completion:** after the strobe that processes the last nibble, go to DONE. DONE asserts `o_alu_done` for exactly one clock, then returns to IDLE.
- **Busy conditions:** `i_instr_execute` while busy is ignored; the decoder must hold off on `o_alu_busy`.
- **Reset (also mid-operation):** A–D = 0, P = 0, `o_carry` = 0, `o_alu_busy` = 0, `o_alu_done` = 0, state IDLE. Reset has priority over every other update in the same clock.

## Timing
- Command is latched on the clock edge where execute is sampled high. `o_alu_busy` rises on that edge.
- The first nibble is processed on the next `i_phases[3]` clock, not the latch clock itself.
- Register, P and carry writes are visible the clock after their strobe.
- `o_alu_done` is high on the clock following the last-nibble strobe. `o_alu_busy` falls together with `o_alu_done`.
- Latency: N phase-3 strobes plus one clock.
- `i_debug_cycle` high on a phase-3 clock skips that nibble. Processing resumes on the next phase-3 clock with debug low; no nibble is lost or duplicated.

## Structure
- `ALU_REG_*`, `ALU_OP_*` (add `ALU_OP_ADD`, `_SUB`, `_AND`, `_OR`, `_EXCH`) and `INSTR_TYPE_*` live in `saturn_def_alu.v`.
- State encodings are local to this block.
- One combinational sub-module, `saturn_alu_nibble`:
  - inputs: op, a[3:0], b[3:0], cin;
  - outputs: result[3:0], cout.
- Register file: 4×64-bit flops in this block.

## Test plan
- **P= 5:** command (dest P, src1 IMM, imm 5, COPY) → P=5 after first strobe; `o_alu_done` one clock; A–D unchanged.
- **Immediate ADD:** A=0x0F, command A=A+IMM (imm 1), field 0..1 → A=0x10, `o_carry`=0.
- **Borrow:** A=0, command A=A−B with B=1, field 0..15 → A=0xFFFFFFFFFFFFFFFF, `o_carry`=1.
- **Wrap and exchange:** field start 14, last 1, EXCH A↔C → only nibbles 14, 15, 0, 1 swapped; exactly 4 strobes elapse.
- **Collision and debug freeze:** second execute during RUN is ignored; debug held across 2 strobes → done delayed by exactly 2 phase-3 periods.
- **Reset mid-op:** reset after the 2nd nibble of a 16-nibble COPY → all registers 0, busy 0, and the next command executes normally.
